// File: rtl/n1_sbus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : n1_sbus_ctrl
//  Description : Stack bus master. Runs one PRS access, with the AGU address
//                and PS/RS tag, as a single pipelined Wishbone cycle. Returns
//                read data and a done, bus-error or timeout pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module n1_sbus_ctrl #(
    parameter int SP_WIDTH    = 12,
    parameter int CELL_WIDTH  = 16,
    parameter int TOUT_CYCLES = 15
) (
    input  logic                  clk_i,
    input  logic                  async_rst_i,
    input  logic [SP_WIDTH-1:0]   sagu2sbus_adr_i,
    input  logic                  sagu2sbus_tga_ps_i,
    input  logic                  sagu2sbus_tga_rs_i,
    input  logic                  prs2sbus_req_i,
    input  logic                  prs2sbus_we_i,
    input  logic [CELL_WIDTH-1:0] prs2sbus_dat_i,
    output logic                  sbus2prs_busy_o,
    output logic                  sbus2prs_done_o,
    output logic [CELL_WIDTH-1:0] sbus2prs_dat_o,
    output logic                  sbus2excpt_berr_o,
    output logic                  sbus2excpt_tout_o,
    output logic                  sbus_cyc_o,
    output logic                  sbus_stb_o,
    output logic                  sbus_we_o,
    output logic [SP_WIDTH-1:0]   sbus_adr_o,
    output logic                  sbus_tga_ps_o,
    output logic                  sbus_tga_rs_o,
    output logic [CELL_WIDTH-1:0] sbus_dat_o,
    input  logic                  sbus_ack_i,
    input  logic                  sbus_err_i,
    input  logic                  sbus_stall_i,
    input  logic [CELL_WIDTH-1:0] sbus_dat_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    // Timeout fires in the last allowed cycle so cyc is high for exactly
    // TOUT_CYCLES cycles; a zero setting disables the comparison entirely.
    localparam bit         TOUT_EN   = (TOUT_CYCLES != 0);
    localparam logic [7:0] TOUT_LAST = 8'(TOUT_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] tout_cnt;
    logic       tout_hit;
    logic       in_access;
    logic       accept;
    logic       done_set;
    logic       berr_set;
    logic       tout_set;
    logic       rd_capture;

    assign in_access = (state == ADDR) || (state == DATA);
    assign tout_hit  = TOUT_EN && in_access && (tout_cnt == TOUT_LAST);

    // State register
    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; timeout overrides ack/err in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (prs2sbus_req_i) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (tout_hit) begin
                    state_nxt = IDLE;
                end else if (!sbus_stall_i) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (tout_hit || sbus_ack_i || sbus_err_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Completion decode; err beats ack, timeout beats both
    always_comb begin
        accept     = (state == IDLE) && prs2sbus_req_i;
        tout_set   = tout_hit;
        berr_set   = (state == DATA) && sbus_err_i && !tout_hit;
        done_set   = (state == DATA) && sbus_ack_i && !sbus_err_i && !tout_hit;
        rd_capture = done_set && !sbus_we_o;
    end

    // Registered bus controls and completion pulses
    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            sbus_cyc_o        <= 1'b0;
            sbus_stb_o        <= 1'b0;
            sbus2prs_busy_o   <= 1'b0;
            sbus2prs_done_o   <= 1'b0;
            sbus2excpt_berr_o <= 1'b0;
            sbus2excpt_tout_o <= 1'b0;
        end else begin
            sbus_cyc_o        <= (state_nxt != IDLE);
            sbus_stb_o        <= (state_nxt == ADDR);
            sbus2prs_busy_o   <= (state_nxt != IDLE);
            sbus2prs_done_o   <= done_set;
            sbus2excpt_berr_o <= berr_set;
            sbus2excpt_tout_o <= tout_set;
        end
    end

    // Request capture: address, tags, direction and write data held for the access
    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            sbus_adr_o    <= '0;
            sbus_tga_ps_o <= 1'b0;
            sbus_tga_rs_o <= 1'b0;
            sbus_we_o     <= 1'b0;
            sbus_dat_o    <= '0;
        end else if (accept) begin
            sbus_adr_o    <= sagu2sbus_adr_i;
            sbus_tga_ps_o <= sagu2sbus_tga_ps_i;
            sbus_tga_rs_o <= sagu2sbus_tga_rs_i;
            sbus_we_o     <= prs2sbus_we_i;
            sbus_dat_o    <= prs2sbus_dat_i;
        end
    end

    // Read data is held until the next successful read
    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            sbus2prs_dat_o <= '0;
        end else if (rd_capture) begin
            sbus2prs_dat_o <= sbus_dat_i;
        end
    end

    // Timeout counter: cleared when an access is accepted, counts while on the bus
    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            tout_cnt <= 8'd0;
        end else if (accept) begin
            tout_cnt <= 8'd0;
        end else if (in_access) begin
            tout_cnt <= tout_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire
